// File: rtl/softmax_pkg.sv
// Shared definitions for the Q6.10 softmax datapath.
package softmax_pkg;

   localparam int unsigned Q610_W = 16;
   localparam logic [Q610_W-1:0] Q610_MIN = 16'h8000;

   // Width of a counter that must hold 0..n inclusive.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/vector_frame_reg.sv
// Output frame holding register: pads lanes at or above cnt and builds the lane mask on load.
module vector_frame_reg
   import softmax_pkg::*;
#(
   parameter int unsigned       N         = 64,
   parameter logic [Q610_W-1:0] PAD_VALUE = Q610_MIN
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load_i,
   input  logic [N*Q610_W-1:0]        fill_i,
   input  logic [cnt_width(N)-1:0]    cnt_i,
   input  logic                       m_ready_i,
   output logic                       free_c,
   output logic                       m_valid_o,
   output logic [N*Q610_W-1:0]        m_data_o,
   output logic [N-1:0]               m_mask_o,
   output logic [cnt_width(N)-1:0]    m_len_o
);

   localparam int unsigned CW = cnt_width(N);

   logic [N*Q610_W-1:0] data_d;
   logic [N-1:0]        mask_d;

   // Lanes below cnt carry real elements; the rest get the pad value.
   always_comb begin
      data_d = '0;
      mask_d = '0;
      for (int i = 0; i < N; i++) begin
         mask_d[i] = (CW'(i) < cnt_i);
         data_d[i*Q610_W +: Q610_W] = mask_d[i] ? fill_i[i*Q610_W +: Q610_W] : PAD_VALUE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_valid_o <= 1'b0;
         m_data_o  <= '0;
         m_mask_o  <= '0;
         m_len_o   <= '0;
      end else if (load_i) begin
         m_valid_o <= 1'b1;
         m_data_o  <= data_d;
         m_mask_o  <= mask_d;
         m_len_o   <= cnt_i;
      end else if (m_ready_i) begin
         m_valid_o <= 1'b0;
      end
   end

   assign free_c = !m_valid_o || m_ready_i;

endmodule

// File: rtl/softmax_vector_loader.sv
// Collects a serial Q6.10 score stream into padded N-lane frames for the max-reduction tree.
module softmax_vector_loader
   import softmax_pkg::*;
#(
   parameter int unsigned       N         = 64,
   parameter logic [Q610_W-1:0] PAD_VALUE = Q610_MIN
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [Q610_W-1:0]          s_data,
   input  logic                       s_last,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [N*Q610_W-1:0]        m_data,
   output logic [N-1:0]               m_lane_valid,
   output logic [N-1:0]               m_lane_mask,
   output logic [cnt_width(N)-1:0]    m_len,
   output logic                       err_no_last
);

   localparam int unsigned CW = cnt_width(N);
   localparam int unsigned IW = $clog2(N);

   typedef enum logic {FILL, PENDING} state_e;

   state_e                     state_q, state_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic                       err_q, err_d;
   logic [N-1:0][Q610_W-1:0]   fill_q;
   logic                       wr_en;
   logic                       load;
   logic                       frame_free;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FILL;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Fill buffer is never cleared: lanes at or above cnt are masked out at transfer.
   always_ff @(posedge clk) begin
      if (wr_en) fill_q[cnt_q[IW-1:0]] <= s_data;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      wr_en   = 1'b0;
      load    = 1'b0;
      case (state_q)
         FILL: begin
            if (s_valid) begin
               wr_en = 1'b1;
               cnt_d = cnt_q + CW'(1);
               if (s_last || (cnt_q == CW'(N - 1))) state_d = PENDING;
               err_d = !s_last && (cnt_q == CW'(N - 1));
            end
         end
         PENDING: begin
            if (frame_free) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   assign s_ready      = (state_q == FILL);
   assign err_no_last  = err_q;
   assign m_lane_valid = {N{m_valid}};

   vector_frame_reg #(
      .N         (N),
      .PAD_VALUE (PAD_VALUE)
   ) u_frame_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load),
      .fill_i    (fill_q),
      .cnt_i     (cnt_q),
      .m_ready_i (m_ready),
      .free_c    (frame_free),
      .m_valid_o (m_valid),
      .m_data_o  (m_data),
      .m_mask_o  (m_lane_mask),
      .m_len_o   (m_len)
   );

endmodule

// File: tb/tb_softmax_vector_loader.sv
// Directed scoreboard bench for softmax_vector_loader (N=64).
module tb_softmax_vector_loader;

   localparam int N  = 64;
   localparam int DW = N * 16;
   localparam int BW = 1024;

   typedef struct {
      logic [DW-1:0] data;
      logic [N-1:0]  mask;
      logic [6:0]    len;
   } frame_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_valid;
   logic          s_ready;
   logic [15:0]   s_data;
   logic          s_last;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic [N-1:0]  m_lane_valid;
   logic [N-1:0]  m_lane_mask;
   logic [6:0]    m_len;
   logic          err_no_last;

   int checks     = 0;
   int errors     = 0;
   int pops       = 0;
   int err_pulses = 0;
   int ncycles    = 0;

   frame_t      sb[$];
   frame_t      last_f;
   logic [15:0] mlane[N];
   int          mcnt = 0;

   softmax_vector_loader #(.N(N), .PAD_VALUE(16'h8000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .s_last       (s_last),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_lane_valid (m_lane_valid),
      .m_lane_mask  (m_lane_mask),
      .m_len        (m_len),
      .err_no_last  (err_no_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame();
      frame_t f;
      for (int i = 0; i < N; i++) begin
         f.data[i*16 +: 16] = (i < mcnt) ? mlane[i] : 16'h8000;
         f.mask[i]          = (i < mcnt);
      end
      f.len  = 7'(mcnt);
      sb.push_back(f);
      last_f = f;
      mcnt   = 0;
   endtask

   task automatic pop_check();
      frame_t f;
      if (sb.size() == 0) begin
         chk("unexpected_frame", BW'(0), BW'(1));
      end else begin
         f = sb.pop_front();
         chk("frame_data", BW'(m_data), BW'(f.data));
         chk("frame_mask", BW'(m_lane_mask), BW'(f.mask));
         chk("frame_len", BW'(m_len), BW'(f.len));
         chk("lane_valid", BW'(m_lane_valid), BW'({N{1'b1}}));
         pops++;
      end
   endtask

   // One clock: observe before the edge, return just after it.
   task automatic cycle(output logic acc);
      @(negedge clk);
      acc = s_valid && s_ready;
      if (err_no_last === 1'b1) err_pulses++;
      if (m_valid === 1'b1 && m_ready === 1'b1) pop_check();
      @(posedge clk);
      #1;
      ncycles++;
   endtask

   task automatic send(input logic [15:0] d, input logic last);
      logic acc;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      acc     = 1'b0;
      for (int t = 0; t < 500 && !acc; t++) cycle(acc);
      chk("send_accept", BW'(acc), BW'(1));
      if (acc) begin
         mlane[mcnt] = d;
         mcnt++;
         if (last || mcnt == N) push_frame();
      end
   endtask

   task automatic idle(input int n);
      logic acc;
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (n) cycle(acc);
   endtask

   initial begin
      logic   acc;
      frame_t fa, fb;
      int     p0, e0, c0;

      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
      idle(2);
      rst_n = 1'b1;

      // Reset state
      chk("rst_m_valid", BW'(m_valid), BW'(0));
      chk("rst_s_ready", BW'(s_ready), BW'(1));
      chk("rst_m_data", BW'(m_data), BW'(0));
      chk("rst_mask", BW'(m_lane_mask), BW'(0));
      chk("rst_len", BW'(m_len), BW'(0));
      chk("rst_err", BW'(err_no_last), BW'(0));

      // Full frame with latency check
      m_ready = 1'b1;
      for (int i = 1; i <= N; i++) send(16'h0400, i == N);
      s_valid = 1'b0;
      chk("full_lat_valid0", BW'(m_valid), BW'(0));
      chk("full_pending_ready", BW'(s_ready), BW'(0));
      idle(1);
      chk("full_lat_valid1", BW'(m_valid), BW'(1));
      chk("full_err", BW'(err_no_last), BW'(0));
      idle(3);

      // Short frame with padding
      send(16'hFC00, 1'b0);
      send(16'h0200, 1'b0);
      send(16'h0100, 1'b1);
      idle(4);

      // Backpressure: A held while B is collected and C waits
      m_ready = 1'b0;
      send(16'h0011, 1'b0);
      send(16'h0022, 1'b1);
      fa = last_f;
      idle(2);
      for (int i = 0; i < 5; i++) send(16'(16'h0100 + i), i == 4);
      fb = last_f;
      chk("bp_ready_after_b", BW'(s_ready), BW'(0));
      s_valid = 1'b1; s_data = 16'h0777; s_last = 1'b0;
      for (int t = 0; t < 95; t++) begin
         cycle(acc);
         chk("bp_hold_data", BW'(m_data), BW'(fa.data));
         chk("bp_hold_len", BW'(m_len), BW'(fa.len));
         chk("bp_ready_low", BW'(s_ready), BW'(0));
      end
      m_ready = 1'b1;
      cycle(acc);
      m_ready = 1'b0;
      chk("bp_b_valid", BW'(m_valid), BW'(1));
      chk("bp_b_data", BW'(m_data), BW'(fb.data));
      chk("bp_ready_back", BW'(s_ready), BW'(1));
      send(16'h0777, 1'b0);
      send(16'h0778, 1'b1);
      m_ready = 1'b1;
      idle(5);
      chk("bp_sb_drained", BW'(sb.size()), BW'(0));

      // Missing last: auto-close at 64, then a 6-element tail
      e0 = err_pulses;
      for (int i = 1; i <= 70; i++) begin
         send(16'(i), i == 70);
         if (i == 64) chk("nolast_err_hi", BW'(err_no_last), BW'(1));
         if (i == 65) chk("nolast_err_lo", BW'(err_no_last), BW'(0));
      end
      idle(4);
      chk("nolast_pulses", BW'(err_pulses - e0), BW'(1));

      // Reset mid-fill discards the partial vector
      for (int i = 0; i < 10; i++) send(16'(16'h0050 + i), 1'b0);
      s_valid = 1'b0;
      rst_n   = 1'b0;
      cycle(acc);
      rst_n   = 1'b1;
      mcnt    = 0;
      chk("midrst_m_valid", BW'(m_valid), BW'(0));
      chk("midrst_s_ready", BW'(s_ready), BW'(1));
      chk("midrst_len", BW'(m_len), BW'(0));
      send(16'h0AAA, 1'b0);
      send(16'h0BBB, 1'b1);
      idle(4);

      // Back-to-back length-1 frames: one every 2 cycles
      p0 = pops;
      c0 = ncycles;
      for (int i = 0; i < 8; i++) send(16'(16'h1000 + i), 1'b1);
      chk("b2b_cycles", BW'(ncycles - c0), BW'(15));
      idle(4);
      chk("b2b_frames", BW'(pops - p0), BW'(8));
      chk("final_sb_empty", BW'(sb.size()), BW'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/softmax_vector_loader.md
Name: softmax_vector_loader

Overview:
- Upstream stage of the Q6.10 softmax max-reduction tree.
- Collects a serial stream of signed 16-bit Q6.10 scores (one per cycle, valid/ready) into an N-lane flat vector.
- Pads unused lanes of short vectors with the most-negative value, so pads never win the max.
- Presents each completed frame to the max tree with a frame-level valid/ready handshake and double buffering, so the next vector can be collected while the previous frame waits.

Parameters:
- N, 64, lanes per frame; power of two, at least 2.
- PAD_VALUE, 16'h8000, Q6.10 value written to unused lanes (-32.0).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- s_valid  in  1  input element valid.
- s_ready  out  1  loader can accept an element.
- s_data  in  16  signed Q6.10 element.
- s_last  in  1  element closes the current vector.
- m_valid  out  1  output frame valid.
- m_ready  in  1  consumer accepts the frame (max-tree enable path).
- m_data  out  N*16  frame; lane i at bits [i*16 +: 16].
- m_lane_valid  out  N  {N{m_valid}}; drives the max tree per-lane valid.
- m_lane_mask  out  N  bit i = 1 when lane i holds a real element.
- m_len  out  $clog2(N+1)  real element count, 1..N.
- err_no_last  out  1  one-cycle pulse: frame auto-closed at N elements without s_last.

Behaviour:
- Reset: rst_n=0 at posedge clears everything.
  - State goes to FILL; fill count goes to 0.
  - m_valid, m_data, m_lane_mask, m_len and err_no_last all become 0.
  - Any partial or pending frame is discarded.
  - s_ready is 1 in the cycle after reset.
- Fill buffer: N x 16 registers plus a count register cnt (0..N).
- State machine: FILL and PENDING.
  - FILL: s_ready=1. On accept (s_valid & s_ready), write s_data to lane cnt and increment cnt.
  - FILL -> PENDING: when the accepted element has s_last=1, or cnt reaches N.
  - Reaching N without s_last raises err_no_last for one cycle, on the edge of closure.
  - Elements after an auto-close start a new vector.
  - PENDING: s_ready=0.
  - PENDING -> FILL: when the output register is free, meaning !m_valid or (m_valid & m_ready) in that cycle.
- Transfer (on the PENDING -> FILL edge):
  - m_data lane i = fill lane i for i<cnt, otherwise PAD_VALUE.
  - m_lane_mask = lanes below cnt set.
  - m_len = cnt; m_valid = 1; cnt = 0.
- Latency: last element accepted at edge k gives m_valid=1 after edge k+1 when the output register is free.
  - Per-frame throughput is len+1 cycles with no backpressure.
- Output hold: while m_valid & !m_ready, m_data, m_lane_mask and m_len must not change.
  - m_valid drops after an edge with m_ready=1 unless a transfer happens at that same edge.
  - A simultaneous drain and transfer gives back-to-back frames with no bubble.
- Stale data: fill lanes at or above cnt are never read. No clear of the fill buffer is needed between frames.
- Sign handling: data is passed through unmodified, with no arithmetic. The sign matters only through PAD_VALUE.
- m_ready while !m_valid: ignored.
- s_data and s_last while !s_ready: ignored.

Decomposition:
- Shared softmax package holds:
  - the Q6.10 width constant (16);
  - Q610_MIN = 16'h8000 (PAD_VALUE default);
  - a count-width function clog2(N+1).
- One natural sub-module, vector_frame_reg: the output holding register with valid/ready, padding mux and mask generation.
- Fill buffer and state machine stay in the top module.

Test Plan:
- Full frame, N=64: stream 0x0400 x64 with s_last on element 64 and m_ready=1.
  - Expect m_valid one cycle after the last accept, all lanes 0x0400, m_lane_mask all ones, m_len=64, err_no_last=0.
- Short frame: 3 elements {0xFC00, 0x0200, 0x0100}, s_last on the 3rd.
  - Expect lanes 0..2 equal to those values, lanes 3..63 = 0x8000, m_lane_mask=0x7, m_len=3.
- Backpressure: m_ready=0 for 100 cycles after frame A; stream frame B (len 5), then start frame C.
  - m_data stays frame A throughout.
  - s_ready=0 after B closes.
  - m_ready=1 at a single edge: B appears at the next edge, and s_ready returns to 1 at that same edge.
- Missing last: 70 elements with no s_last.
  - err_no_last pulses once at element 64, and frame 1 has m_len=64.
  - Elements 65..70 form a partial frame; s_last on element 70 gives m_len=6.
- Reset mid-fill: after 10 elements, pulse rst_n=0 for one cycle.
  - m_valid=0, s_ready=1, and the next 2-element frame with s_last has m_len=2 with no leftover lanes.
- Back-to-back: continuous length-1 frames with m_ready=1.
  - One frame every 2 cycles, and m_valid never drops between overlapping drain and transfer.
